// File: rtl/gen_sensores_if.sv
// Request/response and sensor-drive signals between gen_sensores and whoever
// requests scenarios and supplies the controller's P/A outputs.
interface gen_sensores_if;
  logic       start;
  logic [1:0] modo;
  logic       P;
  logic       A;
  logic       sf;
  logic       sm;
  logic       busy;
  logic       done;
  logic       ok;
  logic       err;

  modport master (
    output start, modo, P, A,
    input  sf, sm, busy, done, ok, err
  );

  modport slave (
    input  start, modo, P, A,
    output sf, sm, busy, done, ok, err
  );
endinterface

// File: rtl/gen_sensores.sv
// Plays one sf/sm passage scenario into the access controller, then judges
// the controller's P/A response within a bounded window.
module gen_sensores #(
  parameter int DWELL   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          reset,
  gen_sensores_if.slave bus
);

  localparam logic [1:0] M_NORMAL  = 2'b00;
  localparam logic [1:0] M_BACK    = 2'b01;
  localparam logic [1:0] M_ABANDON = 2'b10;
  localparam logic [1:0] M_METAL   = 2'b11;
  localparam logic [7:0] DWELL_C   = 8'(DWELL);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, FASE_MF, FASE_M, FALLA, ESPERA, FIN} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] modo_q, modo_d;
  logic       ok_q, ok_d;
  logic       err_q, err_d;
  logic       last_tick;
  logic       exp_hit, nexp_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      modo_q  <= M_NORMAL;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      modo_q  <= modo_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign last_tick = (cnt_q <= 8'd1);

  // Mode 11 expects silence, so any P or A counts against it.
  always_comb begin
    exp_hit  = 1'b0;
    nexp_hit = 1'b0;
    case (modo_q)
      M_NORMAL: begin exp_hit = bus.P; nexp_hit = bus.A; end
      M_BACK,
      M_ABANDON: begin exp_hit = bus.A; nexp_hit = bus.P; end
      default:  begin exp_hit = 1'b0;  nexp_hit = bus.P | bus.A; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    modo_d  = modo_q;
    ok_d    = ok_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.modo == M_METAL) ? FASE_M : FASE_MF;
          cnt_d   = DWELL_C;
          modo_d  = bus.modo;
          ok_d    = 1'b0;
          err_d   = 1'b0;
        end
      end
      FASE_MF: begin
        if (last_tick) begin
          state_d = (modo_q == M_ABANDON) ? FALLA : FASE_M;
          cnt_d   = DWELL_C;
        end
      end
      FASE_M: begin
        if (last_tick) begin
          state_d = (modo_q == M_BACK) ? FALLA : ESPERA;
          cnt_d   = TIMEOUT_C;
        end
      end
      FALLA: begin
        state_d = ESPERA;
        cnt_d   = TIMEOUT_C;
      end
      ESPERA: begin
        if (nexp_hit) begin
          state_d = FIN;
          err_d   = 1'b1;
        end else if (exp_hit) begin
          state_d = FIN;
          ok_d    = 1'b1;
        end else if (last_tick) begin
          state_d = FIN;
          ok_d    = (modo_q == M_METAL);
          err_d   = (modo_q != M_METAL);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.sf = 1'b0;
    bus.sm = 1'b0;
    case (state_q)
      FASE_MF: begin bus.sf = 1'b1; bus.sm = 1'b1; end
      FASE_M:  bus.sm = 1'b1;
      FALLA:   begin bus.sf = 1'b1; bus.sm = (modo_q == M_BACK); end
      default: ;
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == FIN);
  assign bus.ok   = ok_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_gen_sensores.sv
// Scenario bench for gen_sensores: expected per-cycle output vectors are
// queued at start time and popped as the DUT steps through the scenario.
module tb_gen_sensores;
  localparam int D = 4;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec  = 0;
  int   n_fail = 0;
  logic [5:0] exp_q[$];

  gen_sensores_if bus ();

  gen_sensores #(.DWELL(D), .TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {bus.sf, bus.sm, bus.busy, bus.done, bus.ok, bus.err};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: phase windows from the cycle-numbered timing, decision in ESPERA.
  task automatic push_expected(input logic [1:0] m, input int p_at, input int a_at, output int fin);
    int mf_lo, mf_hi, m_lo, m_hi, fl, esp;
    logic okx, errx, pn, an, e, ne, sfx, smx;
    mf_lo = 1; mf_hi = 0; m_lo = 1; m_hi = 0; fl = -1; esp = 0;
    case (m)
      2'b00: begin mf_hi = D; m_lo = D + 1; m_hi = 2 * D; esp = 2 * D + 1; end
      2'b01: begin mf_hi = D; m_lo = D + 1; m_hi = 2 * D; fl = 2 * D + 1; esp = 2 * D + 2; end
      2'b10: begin mf_hi = D; fl = D + 1; esp = D + 2; end
      default: begin m_hi = D; esp = D + 1; end
    endcase
    fin  = esp + T;
    okx  = (m == 2'b11);
    errx = (m != 2'b11);
    for (int n = esp; n < esp + T; n++) begin
      pn = (n == p_at);
      an = (n == a_at);
      e  = (m == 2'b00) ? pn : (m == 2'b11) ? 1'b0 : an;
      ne = (m == 2'b00) ? an : (m == 2'b11) ? (pn | an) : pn;
      if (ne || e) begin
        fin  = n + 1;
        okx  = !ne;
        errx = ne;
        break;
      end
    end
    for (int k = 1; k <= fin + 1; k++) begin
      sfx = (k >= mf_lo && k <= mf_hi) || (k == fl);
      smx = (k >= mf_lo && k <= mf_hi) || (k >= m_lo && k <= m_hi) || (k == fl && m == 2'b01);
      exp_q.push_back({sfx, smx, k <= fin, k == fin, (k >= fin) & okx, (k >= fin) & errx});
    end
  endtask

  task automatic run_scen(input string name, input logic [1:0] m, input int p_at, input int a_at,
                          input int restart_at, input int abort_at);
    int fin, dones;
    logic [5:0] want;
    dones = 0;
    @(negedge clk);
    bus.modo  = m;
    bus.start = 1'b1;
    push_expected(m, p_at, a_at, fin);
    for (int k = 1; k <= fin + 1; k++) begin
      @(negedge clk);
      bus.start = (k == restart_at);
      bus.modo  = ~m;
      bus.P     = (k == p_at);
      bus.A     = (k == a_at);
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_val({name, "_abort"}, {26'd0, obs()}, 32'd0);
        exp_q.delete();
        bus.P = 1'b0;
        bus.A = 1'b0;
        return;
      end
      want = exp_q.pop_front();
      $display("%s cyc %0d out=%b exp=%b", name, k, obs(), want);
      check_val($sformatf("%s_c%0d", name, k), {26'd0, obs()}, {26'd0, want});
      if (bus.done) dones++;
    end
    check_val({name, "_ndone"}, dones, 1);
    bus.start = 1'b0;
    bus.P     = 1'b0;
    bus.A     = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.modo  = 2'b00;
    bus.P     = 1'b0;
    bus.A     = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_state", {26'd0, obs()}, 32'd0);
    rst_n = 1'b1;

    run_scen("m00_ok",      2'b00, 10, 0,  0, 0);
    run_scen("m01_ok",      2'b01, 0,  10, 0, 0);
    run_scen("m10_ok",      2'b10, 0,  6,  0, 0);
    run_scen("m11_quiet",   2'b11, 0,  0,  0, 0);
    run_scen("m00_tmo",     2'b00, 0,  0,  0, 0);
    run_scen("m00_alarm",   2'b00, 0,  10, 0, 0);
    run_scen("m00_both",    2'b00, 10, 10, 0, 0);
    run_scen("m11_door",    2'b11, 7,  0,  0, 0);
    run_scen("m01_late",    2'b01, 5,  11, 0, 0);
    run_scen("m00_restart", 2'b00, 10, 0,  3, 0);
    run_scen("m00_abort",   2'b00, 10, 0,  0, 6);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("abort_hold", {26'd0, obs()}, 32'd0);
    end
    rst_n = 1'b1;
    run_scen("m10_after",   2'b10, 0,  6,  0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
